ahb3lite_apb_bridge: RTL
========================

Name: ahb3lite_apb_bridge

Overview:
- AHB3-Lite slave that converts each accepted AHB transfer into one APB4 transfer. Same clock domain: PCLK is HCLK.
- Connects to one slave port of the AHB3-Lite interconnect and drives a single APB peripheral segment.
- Handles one outstanding transfer; stalls the AHB data phase with HREADYOUT until the APB access completes.

Parameters:
- HADDR_SIZE, 32, AHB address width
- HDATA_SIZE, 32, AHB/APB data width (only 32 supported)
- PADDR_SIZE, 16, APB address width (PADDR = HADDR[PADDR_SIZE-1:0])

Ports:
- HRESETN  in  1  async active-low reset
- HCLK  in  1  clock (also APB clock)
- HSEL  in  1  slave select from interconnect
- HADDR  in  HADDR_SIZE  address
- HWDATA  in  HDATA_SIZE  write data (data phase)
- HRDATA  out  HDATA_SIZE  read data
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size
- HBURST  in  3  ignored (each beat is a separate APB access)
- HPROT  in  4  protection
- HTRANS  in  2  transfer type
- HMASTLOCK  in  1  ignored
- HREADY  in  1  bus-wide ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0=OKAY, 1=ERROR
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PPROT  out  3  {~HPROT[0], 1'b0, HPROT[1]}
- PWRITE  out  1  APB direction
- PSTRB  out  4  byte strobes (0 on reads)
- PADDR  out  PADDR_SIZE  APB address
- PWDATA  out  HDATA_SIZE  APB write data
- PRDATA  in  HDATA_SIZE  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset (async assert, sync release): state IDLE; HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PSTRB=0, PADDR=0, PWDATA=0, PPROT=0. All outputs are registered.
- Accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ/SEQ), sampled only in IDLE. On accept, register HADDR, HWRITE, HSIZE, HPROT.
- IDLE or BUSY HTRANS with HSEL: no action; HREADYOUT stays 1, HRESP stays 0.
- HSIZE > 2 (wider than 32 bits): no APB access. Go to ERR1.
- PSTRB for writes:
  - byte: 4'b0001 << HADDR[1:0]
  - half: HADDR[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- States:
  - IDLE: on accept, HREADYOUT<=0. Next state is WDATA for a write, SETUP for a read.
  - WDATA: capture HWDATA into PWDATA; assert PSEL. Next state SETUP.
  - SETUP: PSEL=1, PENABLE=0, for exactly one cycle. Next state ACCESS (PENABLE<=1).
  - ACCESS: hold all P* outputs while PREADY=0.
    - PREADY & !PSLVERR: PSEL<=0, PENABLE<=0, HRDATA<=PRDATA (reads only), HREADYOUT<=1, HRESP<=0. Next state IDLE.
    - PREADY & PSLVERR: go to ERR1.
  - ERR1: HRESP=1, HREADYOUT=0, PSEL=0, PENABLE=0. Next state ERR2.
  - ERR2: HRESP=1, HREADYOUT=1. Next state IDLE. The cycle after ERR2, HRESP is 0.
- Latency from accept cycle N, with PREADY=1 at the first ACCESS cycle:
  - Read: SETUP at N+1, ACCESS at N+2, HREADYOUT=1 with HRDATA valid at N+3.
  - Write: WDATA at N+1, SETUP at N+2, ACCESS at N+3, HREADYOUT=1 at N+4.
- Back-to-back: the cycle with HREADYOUT=1 (state IDLE) can accept the next transfer. No idle APB cycle is needed between accesses.
- Addressing: PADDR = captured HADDR[PADDR_SIZE-1:0] without alignment. PSTRB is ignored by APB slaves on reads.
- PREADY/PSLVERR are ignored outside ACCESS. PRDATA is sampled only when ACCESS & PREADY.
- HRDATA holds its last value until the next completed read.
- Reset asserted mid-transfer: immediate return to reset values. The partial APB access is abandoned.

Test Plan:
- Single read at HADDR=0x0000_1234, PRDATA=0xDEADBEEF, PREADY=1 immediately -> PADDR=0x1234; PSEL high N+1..N+2, PENABLE high N+2; HREADYOUT=1 and HRDATA=0xDEADBEEF at N+3.
- Byte write at HADDR=0x..02, HWDATA=0x00AB0000 -> PSTRB=4'b0100, PWDATA=0x00AB0000, PWRITE=1; HREADYOUT low for N+1..N+3.
- Read with PREADY held low 3 ACCESS cycles -> P* outputs stable throughout, HREADYOUT stays low; completes the cycle after PREADY rises.
- PSLVERR=1 with PREADY=1 -> two-cycle ERROR: (HRESP=1, HREADYOUT=0) then (HRESP=1, HREADYOUT=1), then OKAY; HSIZE=3 gives the same response with PSEL never asserted.
- Back-to-back write then read, HTRANS=NONSEQ on the completion cycle -> second SETUP follows the completion cycle directly. An IDLE HTRANS gives zero-wait OKAY with PSEL=0.
- HRESETN pulsed low during ACCESS -> PSEL=PENABLE=0, HREADYOUT=1, HRESP=0 immediately. A new read after release completes normally.

Source files
------------

// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB4 master bridge, single clock domain (PCLK = HCLK).
// One outstanding transfer; the AHB data phase is stretched until the APB access ends.
module ahb3lite_apb_bridge #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int PADDR_SIZE = 16
) (
   input  logic                  HRESETN,
   input  logic                  HCLK,
   input  logic                  HSEL,
   input  logic [HADDR_SIZE-1:0] HADDR,
   input  logic [HDATA_SIZE-1:0] HWDATA,
   output logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [3:0]            HPROT,
   input  logic [1:0]            HTRANS,
   input  logic                  HMASTLOCK,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic [2:0]            PPROT,
   output logic                  PWRITE,
   output logic [3:0]            PSTRB,
   output logic [PADDR_SIZE-1:0] PADDR,
   output logic [HDATA_SIZE-1:0] PWDATA,
   input  logic [HDATA_SIZE-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDATA,
      S_SETUP,
      S_ACCESS,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t     r_state;
   logic       w_accept;
   logic [3:0] w_strb;
   logic       w_unused;

   assign w_accept = HSEL & HREADY & HTRANS[1];
   assign w_unused = ^{HBURST, HMASTLOCK, HTRANS[0], HPROT[3:2], HADDR[HADDR_SIZE-1:PADDR_SIZE]};

   always_comb begin
      w_strb = '0;
      case (HSIZE)
         3'd0:    w_strb = 4'b0001 << HADDR[1:0];
         3'd1:    w_strb = HADDR[1] ? 4'b1100 : 4'b0011;
         3'd2:    w_strb = 4'b1111;
         default: w_strb = '0;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         r_state   <= S_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= '0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PSTRB     <= '0;
         PADDR     <= '0;
         PWDATA    <= '0;
         PPROT     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  HREADYOUT <= 1'b0;
                  PADDR     <= HADDR[PADDR_SIZE-1:0];
                  PWRITE    <= HWRITE;
                  PSTRB     <= HWRITE ? w_strb : 4'b0000;
                  PPROT     <= {~HPROT[0], 1'b0, HPROT[1]};
                  // Oversized transfers skip the APB side; reads go straight to SETUP
                  // because no write data has to be waited for.
                  if (HSIZE > 3'd2) begin
                     HRESP   <= 1'b1;
                     r_state <= S_ERR1;
                  end else if (HWRITE) begin
                     r_state <= S_WDATA;
                  end else begin
                     PSEL    <= 1'b1;
                     r_state <= S_SETUP;
                  end
               end
            end
            S_WDATA: begin
               PWDATA  <= HWDATA;
               PSEL    <= 1'b1;
               r_state <= S_SETUP;
            end
            S_SETUP: begin
               PENABLE <= 1'b1;
               r_state <= S_ACCESS;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     HRESP   <= 1'b1;
                     r_state <= S_ERR1;
                  end else begin
                     if (!PWRITE) HRDATA <= PRDATA;
                     HREADYOUT <= 1'b1;
                     r_state   <= S_IDLE;
                  end
               end
            end
            S_ERR1: begin
               HREADYOUT <= 1'b1;
               r_state   <= S_ERR2;
            end
            S_ERR2: begin
               HRESP   <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
